// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map, idle row pattern.
// No logic or state of its own.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam logic [3:0] ROW_IDLE = 4'hF;

    // Indexed by {row, col}; mirrors the legend printed on the keypad.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        return KEY_MAP[{r, c}];
    endfunction

    function automatic logic [1:0] lowest_low(input logic [3:0] col);
        if (!col[0])      return 2'd0;
        else if (!col[1]) return 2'd1;
        else if (!col[2]) return 2'd2;
        else              return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pins plus the decoded key/data bus toward the hex display.
// master = scanner side; slave = keypad/display side.
interface keypad_if;
    logic [3:0]  COL;
    logic [3:0]  ROW;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] data;

    modport master (input COL, output ROW, output key_code, output key_valid,
                    output key_down, output data);
    modport slave  (output COL, input ROW, input key_code, input key_valid,
                    input key_down, input data);
endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous keypad columns, resets to "no key" (all high).
// Latency 2 CLK cycles; no backpressure.
module keypad_sync (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] meta;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner/debouncer; emits hex code strobe and shifts it into a 4-digit register.
// Strobe DEBOUNCE_TICKS scan ticks after detection; no backpressure. Auto-repeat under KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_DELAY   = 64,
    parameter int REPEAT_RATE    = 16
) (
    input  logic     CLK,
    input  logic     RST_N,
    keypad_if.master kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    if (SCAN_DIV < 4 || DEBOUNCE_TICKS < 1 || REPEAT_RATE < 1 || REPEAT_DELAY < REPEAT_RATE) begin : g_bad_cfg
        $error("keypad_scanner: invalid parameter set");
    end

    logic [DIV_W-1:0] div;
    logic             scan_tick;
    logic [3:0]       col_s;
    state_t           state;
    logic [1:0]       row_idx, cand_row, cand_col;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cand_low, cnt_done;
    logic [3:0]       row_q, code_q;
    logic             vld_q, down_q;
    logic [15:0]      data_q;

    keypad_sync u_sync (.CLK(CLK), .RST_N(RST_N), .d(kp.COL), .q(col_s));

    assign scan_tick = (div == DIV_W'(SCAN_DIV - 1));
    assign cand_low  = ~col_s[cand_col];
    assign cnt_nxt   = cnt + CNT_W'(1);
    assign cnt_done  = (cnt_nxt >= CNT_W'(DEBOUNCE_TICKS));

`ifdef KEYPAD_REPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
    logic [HOLD_W-1:0] hold, hold_nxt;
    assign hold_nxt = hold + HOLD_W'(1);
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div      <= '0;
            state    <= SCAN;
            row_idx  <= 2'd0;
            cand_row <= 2'd0;
            cand_col <= 2'd0;
            cnt      <= '0;
            row_q    <= ROW_IDLE;
            code_q   <= 4'h0;
            vld_q    <= 1'b0;
            down_q   <= 1'b0;
            data_q   <= 16'h0000;
`ifdef KEYPAD_REPEAT_EN
            hold     <= '0;
`endif
        end else begin
            vld_q <= 1'b0;
            row_q <= ~(4'b0001 << row_idx);
            div   <= scan_tick ? '0 : div + DIV_W'(1);
            if (scan_tick) begin
                case (state)
                    SCAN: begin
                        if (col_s != ROW_IDLE) begin
                            cand_row <= row_idx;
                            cand_col <= lowest_low(col_s);
                            cnt      <= CNT_W'(1);
                            state    <= DEBOUNCE;
                        end else begin
                            row_idx <= row_idx + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (!cand_low) begin
                            state   <= SCAN;
                            row_idx <= cand_row + 2'd1;
                        end else if (cnt_done) begin
                            state  <= PRESSED;
                            vld_q  <= 1'b1;
                            down_q <= 1'b1;
                            code_q <= key_lookup(cand_row, cand_col);
                            data_q <= {data_q[11:0], key_lookup(cand_row, cand_col)};
`ifdef KEYPAD_REPEAT_EN
                            hold   <= '0;
`endif
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                    PRESSED: begin
                        if (!cand_low) begin
                            state <= RELEASE;
                            cnt   <= CNT_W'(1);
                        end
`ifdef KEYPAD_REPEAT_EN
                        // Rewinding by REPEAT_RATE keeps later repeats on a fixed cadence.
                        else if (hold_nxt >= HOLD_W'(REPEAT_DELAY)) begin
                            hold   <= HOLD_W'(REPEAT_DELAY - REPEAT_RATE);
                            vld_q  <= 1'b1;
                            data_q <= {data_q[11:0], code_q};
                        end else begin
                            hold <= hold_nxt;
                        end
`endif
                    end
                    RELEASE: begin
                        if (cand_low) begin
                            state <= PRESSED;
                        end else if (cnt_done) begin
                            state   <= SCAN;
                            down_q  <= 1'b0;
                            row_idx <= cand_row + 2'd1;
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    assign kp.ROW       = row_q;
    assign kp.key_code  = code_q;
    assign kp.key_valid = vld_q;
    assign kp.key_down  = down_q;
    assign kp.data      = data_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: matrix keypad model, strobe scoreboard with an independent monitor.
module tb_keypad_scanner;
    logic CLK;
    logic rst_n;
    keypad_if kp_if ();

    keypad_scanner #(
        .SCAN_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_DELAY(8), .REPEAT_RATE(4)
    ) dut (
        .CLK(CLK), .RST_N(rst_n), .kp(kp_if.master)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Keypad matrix: a held key pulls its column low while its row is driven low.
    logic [3:0] pressed [4];
    always_comb begin
        logic [3:0] col;
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !kp_if.ROW[r]) col[c] = 1'b0;
        kp_if.COL = col;
    end

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] exp_data;
    int          total;
    int          bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_key(input logic [3:0] code);
        exp_t e;
        exp_data = {exp_data[11:0], code};
        e.code = code;
        e.data = exp_data;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per observed strobe.
    initial begin
        logic prev_vld;
        exp_t e;
        prev_vld = 1'b0;
        forever begin
            @(negedge CLK);
            if (kp_if.key_valid) begin
                check("strobe_not_back_to_back", {31'd0, prev_vld}, 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got key_code=%h data=%h, expected no strobe",
                             kp_if.key_code, kp_if.data);
                end else begin
                    e = sb.pop_front();
                    check("strobe_key_code", {28'd0, kp_if.key_code}, {28'd0, e.code});
                    check("strobe_data", {16'd0, kp_if.data}, {16'd0, e.data});
                end
            end
            prev_vld = kp_if.key_valid;
        end
    end

    task automatic clocks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press(input int r, input int c);
        pressed[r][c] = 1'b1;
    endtask

    task automatic unpress(input int r, input int c);
        pressed[r][c] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            clocks(1);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic wait_up(input string name);
        int n = 0;
        while (kp_if.key_down && n < 400) begin
            clocks(1);
            n++;
        end
        check(name, {31'd0, kp_if.key_down}, 32'd0);
    endtask

    // Returns just after ROW has switched to target, so the next scan tick is 3 clocks away.
    task automatic wait_row_fresh(input logic [3:0] target);
        int n = 0;
        while (kp_if.ROW == target && n < 100) begin clocks(1); n++; end
        n = 0;
        while (kp_if.ROW != target && n < 100) begin clocks(1); n++; end
        check("row_sync", {28'd0, kp_if.ROW}, {28'd0, target});
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
        exp_data = 16'h0000;
        sb.delete();
        clocks(3);
        @(negedge CLK);
        rst_n = 1'b1;
        clocks(1);
    endtask

    initial begin
        logic [1:0] t4_row [5];
        logic [1:0] t4_col [5];
        logic [3:0] t4_code [5];
        t4_row  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
        t4_col  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        t4_code = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h0};
        total = 0;
        bad = 0;
        exp_data = 16'h0000;
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
        rst_n = 1'b0;

        // 1: reset values, then row rotation
        clocks(3);
        check("reset_row", {28'd0, kp_if.ROW}, 32'hF);
        check("reset_key_code", {28'd0, kp_if.key_code}, 32'h0);
        check("reset_key_valid", {31'd0, kp_if.key_valid}, 32'h0);
        check("reset_key_down", {31'd0, kp_if.key_down}, 32'h0);
        check("reset_data", {16'd0, kp_if.data}, 32'h0);
        @(negedge CLK);
        rst_n = 1'b1;
        clocks(1);
        check("row_first", {28'd0, kp_if.ROW}, 32'hE);
        clocks(4);
        check("row_second", {28'd0, kp_if.ROW}, 32'hD);
        clocks(4);
        check("row_third", {28'd0, kp_if.ROW}, 32'hB);
        clocks(4);
        check("row_fourth", {28'd0, kp_if.ROW}, 32'h7);
        clocks(4);
        check("row_wrap", {28'd0, kp_if.ROW}, 32'hE);

        // 2: single key (1,2) -> 6
        press(1, 2);
        expect_key(4'h6);
        wait_drain("t2_strobe");
        check("t2_key_down", {31'd0, kp_if.key_down}, 32'd1);
        check("t2_data", {16'd0, kp_if.data}, 32'h0006);
        unpress(1, 2);
        clocks(1);
        check("t2_down_holds", {31'd0, kp_if.key_down}, 32'd1);
        wait_up("t2_release");
        clocks(8);

        // 3: bounce on (0,0) for two ticks only
        wait_row_fresh(4'hE);
        press(0, 0);
        clocks(6);
        unpress(0, 0);
        begin
            int n = 0;
            while (kp_if.ROW == 4'hE && n < 40) begin clocks(1); n++; end
        end
        check("t3_next_row", {28'd0, kp_if.ROW}, 32'hD);
        check("t3_key_down", {31'd0, kp_if.key_down}, 32'd0);
        clocks(8);

        // 4: key sequence from a fresh register
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            press(t4_row[i], t4_col[i]);
            expect_key(t4_code[i]);
            wait_drain("t4_strobe");
            check("t4_data", {16'd0, kp_if.data}, {16'd0, exp_data});
            unpress(t4_row[i], t4_col[i]);
            wait_up("t4_release");
            clocks(4);
        end

        // 5: two keys, scan order wins, second reported after first released
        wait_row_fresh(4'hE);
        press(0, 0);
        press(2, 1);
        expect_key(4'h1);
        wait_drain("t5_first");
        unpress(0, 0);
        expect_key(4'h8);
        wait_drain("t5_second");
        unpress(2, 1);
        wait_up("t5_release");
        clocks(4);

        // 6a: reset while a key is held
        press(1, 1);
        expect_key(4'h5);
        wait_drain("t6_press");
        rst_n = 1'b0;
        #1;
        check("t6_rst_row", {28'd0, kp_if.ROW}, 32'hF);
        check("t6_rst_key_down", {31'd0, kp_if.key_down}, 32'h0);
        check("t6_rst_key_code", {28'd0, kp_if.key_code}, 32'h0);
        check("t6_rst_data", {16'd0, kp_if.data}, 32'h0);
        unpress(1, 1);
        apply_reset();

        // 6b: long hold of key 5 (18 ticks after first strobe)
        press(1, 1);
        expect_key(4'h5);
        wait_drain("t6_hold_first");
`ifdef KEYPAD_REPEAT_EN
        expect_key(4'h5);
        expect_key(4'h5);
        expect_key(4'h5);
`endif
        clocks(68);
        unpress(1, 1);
        wait_up("t6_release");
        wait_drain("t6_repeats");
        clocks(20);

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
